fifo_regs_flags: RTL

- Parametrised successor to the team's register-based FIFO: single clock, register-array storage.
- Adds a fill-level output, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Output mode is selectable: show-ahead, or registered with a read-valid strobe.
- Sits between producer/consumer blocks (UART, SPI, stream glue) that need early back-pressure and error reporting instead of simulation-only checks.

---
 rtl/fifo_regs_flags.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_regs_flags.sv
// Single-clock register-array FIFO with fill level,
// almost-full/almost-empty flags and sticky error flags.
module fifo_regs_flags #(
   parameter int g_WIDTH    = 8,
   parameter int g_DEPTH    = 32,
   parameter int g_AF_LEVEL = 28,
   parameter int g_AE_LEVEL = 4,
   parameter int g_REG_OUT  = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_wr_en,
   input  logic [g_WIDTH-1:0]           i_wr_data,
   output logic                         o_full,
   output logic                         o_af,
   input  logic                         i_rd_en,
   output logic [g_WIDTH-1:0]           o_rd_data,
   output logic                         o_rd_valid,
   output logic                         o_empty,
   output logic                         o_ae,
   output logic [$clog2(g_DEPTH+1)-1:0] o_count,
   input  logic                         i_clr_err,
   output logic                         o_wr_ovf,
   output logic                         o_rd_udf
);

   localparam int c_IW = $clog2(g_DEPTH);
   localparam int c_CW = $clog2(g_DEPTH + 1);
   localparam logic [c_IW-1:0] c_LAST  = c_IW'(g_DEPTH - 1);
   localparam logic [c_IW-1:0] c_ONE_I = c_IW'(1);
   localparam logic [c_CW-1:0] c_ONE_C = c_CW'(1);
   localparam logic [c_CW-1:0] c_FULL  = c_CW'(g_DEPTH);
   localparam logic [c_CW-1:0] c_AF    = c_CW'(g_AF_LEVEL);
   localparam logic [c_CW-1:0] c_AE    = c_CW'(g_AE_LEVEL);

   if (g_WIDTH < 1 || g_DEPTH < 2 ||
       g_AF_LEVEL < 1 || g_AF_LEVEL > g_DEPTH ||
       g_AE_LEVEL < 0 || g_AE_LEVEL > g_DEPTH - 1 ||
       (g_REG_OUT != 0 && g_REG_OUT != 1)) begin : g_bad_param
      $error("fifo_regs_flags: parameter out of range");
   end

   logic [g_WIDTH-1:0] r_mem [g_DEPTH];
   logic [c_IW-1:0]    r_wr_idx;
   logic [c_IW-1:0]    r_rd_idx;
   logic [c_CW-1:0]    r_count;
   logic               r_wr_ovf;
   logic               r_rd_udf;
   logic               w_full;
   logic               w_empty;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic [g_WIDTH-1:0] w_rd_word;

   // Flags decode the count register; accepts use start-of-cycle flags
   always_comb begin
      w_full    = (r_count == c_FULL);
      w_empty   = (r_count == '0);
      w_wr_acc  = i_wr_en && !w_full;
      w_rd_acc  = i_rd_en && !w_empty;
      w_rd_word = r_mem[r_rd_idx];
   end

   // Storage is deliberately left unreset
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) r_mem[r_wr_idx] <= i_wr_data;
   end

   // Pointers wrap at g_DEPTH-1 so any depth works
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
      end else begin
         if (w_wr_acc)
            r_wr_idx <= (r_wr_idx == c_LAST) ? '0 : r_wr_idx + c_ONE_I;
         if (w_rd_acc)
            r_rd_idx <= (r_rd_idx == c_LAST) ? '0 : r_rd_idx + c_ONE_I;
      end
   end

   // Fill level moves only on accepted operations
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         r_count <= r_count + c_ONE_C;
      end else if (w_rd_acc && !w_wr_acc) begin
         r_count <= r_count - c_ONE_C;
      end
   end

   // Sticky errors; a new error in the clear cycle wins
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ovf <= 1'b0;
         r_rd_udf <= 1'b0;
      end else begin
         if (i_wr_en && w_full)       r_wr_ovf <= 1'b1;
         else if (i_clr_err)          r_wr_ovf <= 1'b0;
         if (i_rd_en && w_empty)      r_rd_udf <= 1'b1;
         else if (i_clr_err)          r_rd_udf <= 1'b0;
      end
   end

   if (g_REG_OUT != 0) begin : g_reg_out
      logic [g_WIDTH-1:0] r_rd_data;
      logic               r_rd_valid;

      // Registered read: one-cycle valid strobe, data held otherwise
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_data <= w_rd_word;
         end
      end

      assign o_rd_data  = r_rd_data;
      assign o_rd_valid = r_rd_valid;
   end else begin : g_show_ahead
      assign o_rd_data  = w_rd_word;
      assign o_rd_valid = !w_empty;
   end

   assign o_full   = w_full;
   assign o_empty  = w_empty;
   assign o_af     = (r_count >= c_AF);
   assign o_ae     = (r_count <= c_AE);
   assign o_count  = r_count;
   assign o_wr_ovf = r_wr_ovf;
   assign o_rd_udf = r_rd_udf;

endmodule
